poly_stream_arbiter: RTL

POLY_STREAM_ARBITER -- requirements
Module: poly_stream_arbiter

---
 rtl/poly_stream_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/poly_stream_arbiter.sv
// Two-requester polynomial-burst arbiter: grants one AXI-Stream source for a full
// polynomial (BEATS_PER_POLY beats), round-robin between bursts, with a regenerated tlast.
module poly_stream_arbiter #(
    parameter int DWIDTH         = 256,
    parameter int KEEP_WIDTH     = DWIDTH / 8,
    parameter int BEATS_PER_POLY = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH-1:0]     s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DWIDTH-1:0]     s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic [DWIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tid,
    output logic                  busy,
    output logic                  err_tlast
);
    localparam int CW = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_POLY - 1);

    typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;   // 1 = s1 was served last, so s0 wins a tie
    logic          tid_q;
    logic          err_q;

    logic in0, in1, at_last, hs, sel_tlast;

    assign in0       = (state == BURST0);
    assign in1       = (state == BURST1);
    assign at_last   = (cnt == LAST_BEAT);
    assign sel_tlast = in1 ? s1_axis_tlast : s0_axis_tlast;

    assign m_axis_tvalid  = (in0 & s0_axis_tvalid) | (in1 & s1_axis_tvalid);
    assign m_axis_tdata   = in0 ? s0_axis_tdata : (in1 ? s1_axis_tdata : '0);
    assign m_axis_tkeep   = in0 ? s0_axis_tkeep : (in1 ? s1_axis_tkeep : '0);
    assign m_axis_tlast   = (in0 | in1) & at_last;
    assign s0_axis_tready = in0 & m_axis_tready;
    assign s1_axis_tready = in1 & m_axis_tready;
    assign m_axis_tid     = tid_q;
    assign busy           = (state != IDLE);
    assign err_tlast      = err_q;
    assign hs             = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            tid_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
                        state <= BURST0;
                        tid_q <= 1'b0;
                    end else if (s1_axis_tvalid) begin
                        state <= BURST1;
                        tid_q <= 1'b1;
                    end
                end
                BURST0, BURST1: begin
                    if (hs) begin
                        // Input tlast is only audited; sequencing uses the beat counter.
                        err_q <= (sel_tlast != at_last);
                        if (at_last) begin
                            cnt        <= '0;
                            last_grant <= in1;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
